// File: rtl/proc_datapath_if.sv
// Control strobes, data input and observable outputs of the processor datapath.
// master = controller side (drives strobes), slave = datapath side.
interface proc_datapath_if #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned IR_W   = 10
);
  logic [DATA_W-1:0] din;
  logic              ir_in;
  logic [7:0]        r_in;
  logic [7:0]        r_out;
  logic              dinout;
  logic              g_out;
  logic              a_in;
  logic              g_in;
  logic              add_sub;
  logic [2:0]        dbg_sel;
  logic [IR_W-1:0]   ir;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] dbg_data;
  logic              g_zero;
  logic              g_carry;
  logic              bus_conflict;

  modport master (
    output din, ir_in, r_in, r_out, dinout, g_out, a_in, g_in, add_sub, dbg_sel,
    input  ir, bus, dbg_data, g_zero, g_carry, bus_conflict
  );

  modport slave (
    input  din, ir_in, r_in, r_out, dinout, g_out, a_in, g_in, add_sub, dbg_sel,
    output ir, bus, dbg_data, g_zero, g_carry, bus_conflict
  );
endinterface

// File: rtl/proc_datapath.sv
// Processor datapath: R0..R7, A, G, IR, priority bus mux, add/sub unit, G status
// flags and a sticky bus-conflict detector.
module proc_datapath #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned IR_W   = 10
) (
  input logic             clock,
  input logic             resetn,
  proc_datapath_if.slave  dp
);

  logic [DATA_W-1:0] r_q [8];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] g_q;
  logic [IR_W-1:0]   ir_q;
  logic              g_zero_q;
  logic              g_carry_q;
  logic              conflict_q;

  logic [DATA_W-1:0] bus;
  logic [DATA_W:0]   alu_res;
  logic [IR_W-1:0]   ir_din;
  logic              multi_src;

  // IR is fed straight from din, resized to the IR width.
  if (IR_W > DATA_W) begin : g_ir_ext
    assign ir_din = {{(IR_W - DATA_W){1'b0}}, dp.din};
  end else begin : g_ir_trunc
    assign ir_din = dp.din[IR_W-1:0];
  end

  // Bus mux: dinout > g_out > r_out[0] > ... > r_out[7]; zero when idle.
  always_comb begin
    bus = '0;
    for (int i = 7; i >= 0; i--) begin
      if (dp.r_out[i]) bus = r_q[i];
    end
    if (dp.g_out)  bus = g_q;
    if (dp.dinout) bus = dp.din;
  end

  // Two or more simultaneous bus drivers.
  always_comb begin
    multi_src = ($countones({dp.dinout, dp.g_out, dp.r_out}) >= 2);
  end

  // One extra bit holds the add carry-out, or the borrow of the subtract.
  always_comb begin
    if (dp.add_sub) alu_res = {1'b0, a_q} - {1'b0, bus};
    else            alu_res = {1'b0, a_q} + {1'b0, bus};
  end

  // All state: synchronous active-low reset wins over every strobe.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) r_q[i] <= '0;
      a_q        <= '0;
      g_q        <= '0;
      ir_q       <= '0;
      g_zero_q   <= 1'b0;
      g_carry_q  <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (dp.r_in[i]) r_q[i] <= bus;
      end
      if (dp.a_in)  a_q  <= bus;
      if (dp.ir_in) ir_q <= ir_din;
      if (dp.g_in) begin
        g_q       <= alu_res[DATA_W-1:0];
        g_zero_q  <= (alu_res[DATA_W-1:0] == '0);
        g_carry_q <= alu_res[DATA_W];
      end
      if (multi_src) conflict_q <= 1'b1;
    end
  end

  assign dp.bus          = bus;
  assign dp.dbg_data     = r_q[dp.dbg_sel];
  assign dp.ir           = ir_q;
  assign dp.g_zero       = g_zero_q;
  assign dp.g_carry      = g_carry_q;
  assign dp.bus_conflict = conflict_q;

endmodule

// File: doc/proc_datapath.md
Name: proc_datapath

Overview:
- Datapath stage that executes the one-hot control strobes issued by the processor control FSM.
- Contains the general registers R0..R7, the operand register A, the result register G, the instruction register IR, the shared bus multiplexer and the add/sub unit.
- Also holds status flags for G.
- Feeds IR back to the controller.
- Exposes the bus and a debug read port to the top level.

Parameters:
- DATA_W, 9, width of bus, DIN, R0..R7, A and G.
- IR_W, 10, width of the instruction register; loaded from DIN, zero-extended when IR_W > DATA_W, truncated to the low bits when IR_W < DATA_W.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- din  in  DATA_W  external data / immediate input.
- ir_in  in  1  load IR from din.
- r_in  in  8  write enables; bit i loads Ri from bus.
- r_out  in  8  bus drive selects; bit i drives Ri onto the bus.
- dinout  in  1  drive din onto the bus.
- g_out  in  1  drive G onto the bus.
- a_in  in  1  load A from bus.
- g_in  in  1  load G with the add/sub result.
- add_sub  in  1  0 = add (A + bus), 1 = subtract (A - bus); sampled only when g_in = 1.
- dbg_sel  in  3  register index for the debug port.
- ir  out  IR_W  instruction register contents, to the controller.
- bus  out  DATA_W  current bus value, combinational.
- dbg_data  out  DATA_W  R[dbg_sel], combinational.
- g_zero  out  1  registered; 1 when the last value loaded into G was 0.
- g_carry  out  1  registered; carry-out of the add, or borrow of the sub (1 when A < bus unsigned).
- bus_conflict  out  1  sticky; set when more than one bus source was selected in a cycle.

Behaviour:
- Reset: while resetn = 0 at a rising edge, R0..R7, A, G, IR, g_zero, g_carry and bus_conflict all clear to 0. Reset overrides every strobe asserted in the same cycle. Reset mid-operation discards any partial result.
- Bus mux (combinational), fixed priority: dinout > g_out > r_out[0] > r_out[1] > ... > r_out[7]. When no source is selected, bus = 0.
- Register writes on the rising edge:
  - Ri <= bus when r_in[i] = 1.
  - Several r_in bits may be set at once; every selected register loads the same bus value.
  - A <= bus when a_in = 1.
  - IR <= din when ir_in = 1. IR does not go through the bus.
- ALU: G <= (A + bus) or (A - bus) mod 2^DATA_W, using the A and bus values present in the cycle g_in = 1. The result is available on the bus through g_out no earlier than the next cycle, so latency from g_in to a visible result is 1 clock.
- Flags: g_zero and g_carry update only on cycles with g_in = 1 and hold otherwise. g_carry is bit DATA_W of the (DATA_W+1)-bit sum, or the borrow for a subtract.
- Simultaneous events:
  - a_in and g_in in the same cycle: G uses the old A, and A then loads the bus.
  - g_out and g_in in the same cycle: the bus shows the old G, and G then updates.
  - r_out[i] and r_in[i] in the same cycle: Ri reloads its own value and does not change.
  - ir_in together with any bus operation: both take effect independently.
- Conflict detection: bus_conflict sets at the edge after any cycle with two or more of {dinout, g_out, r_out[7:0]} asserted. It stays set until reset. The bus still resolves by priority.
- Debug port: dbg_data = R[dbg_sel], combinational, with no side effects.
- Wrap-around: arithmetic is unsigned modulo 2^DATA_W. Overflow is not flagged, apart from g_carry.

Test Plan:
- Reset: preload R3 = 0x1A5, assert resetn = 0 for 1 cycle together with r_in = 0xFF and dinout = 1, din = 0x0AA → all registers, ir and flags read 0; bus_conflict = 0.
- MVI then MV:
  - dinout = 1, din = 0x055, r_in[2] = 1 → next cycle dbg_sel = 2 gives 0x055.
  - r_out[2] = 1, r_in[5] = 1 → R5 = 0x055.
  - bus = 0 when no sources are selected.
- ADD with wrap: R0 = 0x1F0, R1 = 0x020.
  - Cycle 1: r_out[0] = 1, a_in = 1.
  - Cycle 2: r_out[1] = 1, g_in = 1, add_sub = 0.
  - Cycle 3: g_out = 1, r_in[0] = 1.
  - Expected: R0 = 0x010, g_carry = 1, g_zero = 0.
- SUB to zero and borrow:
  - A = 0x007, bus = 0x007, add_sub = 1 → G = 0x000, g_zero = 1, g_carry = 0.
  - Then A = 0x003, bus = 0x005 → G = 0x1FE, g_carry = 1, g_zero = 0.
- Simultaneous strobes:
  - G = 0x011, A = 0x001, bus = R4 = 0x002, with a_in, g_in and g_out all asserted (g_out wins priority, bus = 0x011) → G = 0x012, A = 0x011.
  - bus_conflict = 1 next cycle because g_out and r_out[4] were both set.
  - bus_conflict stays 1 across 3 further clean cycles and clears only on reset.
- IR load: din = 0x1C3, ir_in = 1 → ir = 10'h1C3 next cycle; bus and registers unchanged.
